// File: rtl/spi_mem_burst_if.sv
// Handshake bundle between the SPI command decoder and spi_mem_burst:
// command channel, write-data channel, read-data channel and status.
interface spi_mem_burst_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              clr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              init_done;

    modport master (
        output clr, cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, init_done
    );

    modport slave (
        input  clr, cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, init_done
    );
endinterface

// File: rtl/spi_mem_burst.sv
// Single-port DATA_W x 2**ADDR_W RAM with wrapping burst reads/writes and a
// sequential clear sweep that runs after reset and on a clr request.
module spi_mem_burst #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                LEN_W    = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    spi_mem_burst_if.slave bus_io
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;      // sweep pointer in INIT, burst address otherwise
    logic [LEN_W-1:0]  rem_q;
    logic              more_q;      // read beats still waiting to be loaded
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              busy_q;
    logic              idle_q;
    logic              wr_ready_q;
    logic              init_done_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_accept;
    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = INIT_VAL;

        cmd_fire  = idle_q && !bus_io.clr && bus_io.cmd_valid;
        wr_fire   = wr_ready_q && bus_io.wr_valid;
        rd_accept = rd_valid_q && bus_io.rd_ready;

        // The first beat is fetched on the handshake edge itself; later beats
        // whenever the output register is empty or being drained.
        rd_load = (cmd_fire && !bus_io.cmd_wr) ||
                  ((state_q == ST_READ) && more_q && (!rd_valid_q || rd_accept));
        rd_addr = cmd_fire ? bus_io.cmd_addr : addr_q;

        if (state_q == ST_INIT) begin
            mem_we = 1'b1;
        end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_wdata = bus_io.wr_data;
        end
    end

    // NOTE: the array has no reset; its contents are cleared by the INIT sweep instead.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            addr_q      <= '0;
            rem_q       <= '0;
            more_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b1;
            idle_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (rd_load) begin
                rd_data_q  <= mem[rd_addr];
                rd_valid_q <= 1'b1;
            end else if (rd_accept) begin
                rd_valid_q <= 1'b0;
            end

            unique case (state_q)
                ST_INIT: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        idle_q      <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (bus_io.clr) begin
                        state_q <= ST_INIT;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        idle_q  <= 1'b0;
                    end else if (cmd_fire) begin
                        busy_q <= 1'b1;
                        idle_q <= 1'b0;
                        if (bus_io.cmd_wr) begin
                            state_q    <= ST_WRITE;
                            addr_q     <= bus_io.cmd_addr;
                            rem_q      <= bus_io.cmd_len;
                            wr_ready_q <= 1'b1;
                        end else begin
                            // Beat 0 is loaded on this edge, so track the beats after it.
                            state_q <= ST_READ;
                            addr_q  <= bus_io.cmd_addr + ADDR_W'(1);
                            rem_q   <= bus_io.cmd_len - LEN_W'(1);
                            more_q  <= (bus_io.cmd_len != '0);
                        end
                    end
                end

                ST_WRITE: begin
                    if (wr_fire) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - LEN_W'(1);
                        if (rem_q == '0) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            idle_q     <= 1'b1;
                            wr_ready_q <= 1'b0;
                        end
                    end
                end

                ST_READ: begin
                    if (rd_load) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - LEN_W'(1);
                        if (rem_q == '0) begin
                            more_q <= 1'b0;
                        end
                    end else if (rd_accept && !more_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        idle_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_INIT;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign bus_io.cmd_ready = idle_q && !bus_io.clr;
    assign bus_io.wr_ready  = wr_ready_q;
    assign bus_io.rd_valid  = rd_valid_q;
    assign bus_io.rd_data   = rd_data_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.init_done = init_done_q;
endmodule

// File: doc/spi_mem_burst.md
Name: spi_mem_burst

Overview:
- Parametrised successor to the SPI-side byte memory: a DATA_W x 2**ADDR_W single-port RAM behind a command/data handshake interface.
- Supports burst reads and writes with auto-incrementing, wrapping address.
- Performs a sequential clear sweep after reset and on request, instead of clearing the whole array in a single cycle.
- Sits between the SPI slave command decoder and the register/data path.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
LEN_W, 4, burst length field width; a burst is cmd_len+1 beats (1..2**LEN_W)
INIT_VAL, 0, value written to every word by the clear sweep (DATA_W bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
clr  in  1  clear request; sampled only in IDLE
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  LEN_W  beats minus one
wr_valid  in  1  write data valid
wr_ready  out  1  write data ready
wr_data  in  DATA_W  write data
rd_valid  out  1  read data valid
rd_ready  in  1  read data accepted
rd_data  out  DATA_W  read data (registered)
busy  out  1  state != IDLE
init_done  out  1  high once the first clear sweep has completed; stays high until next rst

Behaviour:
- rst low (asynchronous): state=INIT, sweep pointer=0, rd_valid=0, rd_data=0, init_done=0, busy=1, cmd_ready=0, wr_ready=0. RAM contents are not reset directly; the sweep clears them.
- States: INIT, IDLE, WRITE, READ.
- INIT:
  - Each cycle writes INIT_VAL to mem[ptr] and increments ptr.
  - After the write of address DEPTH-1, go to IDLE and set init_done=1.
  - The sweep takes exactly DEPTH cycles after rst deassertion.
- IDLE:
  - cmd_ready = !clr.
  - clr=1: go to INIT with ptr=0. clr has priority; a simultaneous cmd_valid is not accepted.
  - cmd_valid & cmd_ready: latch addr=cmd_addr and remaining=cmd_len, then go to WRITE if cmd_wr=1, else READ.
- WRITE:
  - wr_ready=1.
  - Each wr_valid & wr_ready edge writes wr_data to mem[addr], sets addr=(addr+1) mod DEPTH, and decrements remaining.
  - The beat with remaining==0 returns the FSM to IDLE on that edge.
  - wr_valid low stalls the burst with no timeout.
- READ:
  - rd_data is registered. A beat is loaded (rd_data=mem[addr], rd_valid=1, addr++ with wrap) when no beat is outstanding or the current beat is accepted (rd_valid & rd_ready), and beats remain.
  - First rd_valid: the cycle after the command handshake edge.
  - With rd_ready held high: one beat per cycle, no bubbles.
  - rd_ready low: rd_valid and rd_data hold stable.
  - When the last beat is accepted: rd_valid=0 and the FSM goes to IDLE on the same edge; cmd_ready is high in the following cycle.
- Address arithmetic is modulo DEPTH (e.g., DEPTH-1 -> 0). Burst count arithmetic is unsigned over LEN_W bits.
- A write beat is visible to any read command accepted after it. There is no read/write overlap, since the port is single.
- clr in WRITE, READ or INIT is ignored; it is not queued.
- rst asserted mid-burst aborts immediately. The partial burst leaves already-written words unchanged until the sweep overwrites them; after reset the block re-enters INIT.
- Outputs other than rd_data and init_done are functions of the state, plus clr for cmd_ready.

Test Plan:
- Reset, DEPTH=256: deassert rst, count cycles until init_done=1 -> exactly 256; cmd_ready stays 0 throughout; then a read burst at 0x00 with len=15 returns 16x 0x00.
- Write burst at 0x10, len=3, data A1,A2,A3,A4 with wr_valid gaps -> exactly 4 accepted beats, back in IDLE; read burst at 0x10, len=3 returns A1..A4 with rd_valid one cycle after the handshake.
- Wrap: write at 0xFE, len=3, data 11,22,33,44 -> mem[FE]=11, mem[FF]=22, mem[00]=33, mem[01]=44; read back at 0xFE, len=3 matches.
- Backpressure: read len=2 with rd_ready low for 3 cycles on beat 1 -> rd_data held constant; all 3 beats delivered in order; busy drops only after the last acceptance.
- Simultaneous clr and cmd_valid in IDLE -> command not accepted, re-sweep runs 256 cycles, prior data reads back as INIT_VAL.
- rst pulsed low mid-write (after 2 of 8 beats) -> outputs immediately take their reset values, INIT restarts, and all words read as INIT_VAL afterwards.
